// File: rtl/eq_compare_arbiter_if.sv
// Handshake bundle for the shared equality comparator: N_REQ operand-pair
// requesters, one back-pressurable response channel and statistics counters.
interface eq_compare_arbiter_if #(
  parameter int WIDTH = 3,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic                   resp_eq;
  logic                   clr_counts;
  logic [CNT_W-1:0]       cmp_count;
  logic [CNT_W-1:0]       match_count;

  modport master (
    output req_valid, req_a, req_b, resp_ready, clr_counts,
    input  req_ready, resp_valid, resp_id, resp_eq, cmp_count, match_count
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, clr_counts,
    output req_ready, resp_valid, resp_id, resp_eq, cmp_count, match_count
  );
endinterface

// File: rtl/eq_compare_arbiter.sv
// One WIDTH-bit equality comparator shared round-robin between N_REQ requesters,
// with a single registered response slot and saturating compare/match counters.
module eq_compare_arbiter #(
  parameter int WIDTH = 3,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  eq_compare_arbiter_if.slave bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + CNT_W'(1);
  endfunction

  logic [ID_W-1:0]  rr_ptr;
  logic [N_REQ-1:0] eq_vec;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  hi_idx, lo_idx, gnt_idx, next_ptr;
  logic             hi_hit, gnt_any, can_accept, xfer, pair_eq;

  logic             vld_p1;
  logic [ID_W-1:0]  id_p1;
  logic             eq_p1;
  logic [CNT_W-1:0] cmp_cnt, match_cnt;

  always_comb begin
    eq_vec = '0;
    for (int i = 0; i < N_REQ; i++)
      eq_vec[i] = (bus.req_a[i*WIDTH +: WIDTH] == bus.req_b[i*WIDTH +: WIDTH]);
  end

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_idx = '0;
    hi_hit = 1'b0;
    lo_idx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (bus.req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
        hi_idx = ID_W'(i);
        hi_hit = 1'b1;
      end
      if (bus.req_valid[i])
        lo_idx = ID_W'(i);
    end
  end

  assign gnt_any    = |bus.req_valid;
  assign gnt_idx    = hi_hit ? hi_idx : lo_idx;
  assign grant      = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  assign can_accept = !vld_p1 || bus.resp_ready;
  assign xfer       = can_accept && gnt_any;
  assign pair_eq    = |(grant & eq_vec);
  assign next_ptr   = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);

  assign bus.req_ready = can_accept ? grant : '0;

  // Stage p1: registered compare result and statistics
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      vld_p1    <= 1'b0;
      id_p1     <= '0;
      eq_p1     <= 1'b0;
      rr_ptr    <= '0;
      cmp_cnt   <= '0;
      match_cnt <= '0;
    end else begin
      if (xfer) begin
        vld_p1 <= 1'b1;
        id_p1  <= gnt_idx;
        eq_p1  <= pair_eq;
        rr_ptr <= next_ptr;
      end else if (bus.resp_ready) begin
        vld_p1 <= 1'b0;
      end

      if (bus.clr_counts) begin
        cmp_cnt   <= '0;
        match_cnt <= '0;
      end else if (xfer) begin
        cmp_cnt <= sat_inc(cmp_cnt);
        if (pair_eq)
          match_cnt <= sat_inc(match_cnt);
      end
    end
  end

  assign bus.resp_valid  = vld_p1;
  assign bus.resp_id     = id_p1;
  assign bus.resp_eq     = eq_p1;
  assign bus.cmp_count   = cmp_cnt;
  assign bus.match_count = match_cnt;

endmodule

// File: tb/tb_eq_compare_arbiter.sv
// Directed bench for eq_compare_arbiter: reset, single compares, round-robin order,
// back-pressure, wrap/skip, counter saturation and clear priority.
module tb_eq_compare_arbiter;
  localparam int WIDTH = 3;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 16;

  logic CLK = 1'b0;
  logic ASYNCRESETN;

  always #5 CLK = ~CLK;

  eq_compare_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  eq_compare_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .bus        (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_pair(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  initial begin
    ASYNCRESETN    = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    bus.clr_counts = 1'b0;
    step();
    step();
    ASYNCRESETN = 1'b1;
    #1;
    chk("reset_resp_valid", 32'(bus.resp_valid), 0);
    chk("reset_req_ready", 32'(bus.req_ready), 0);
    chk("reset_cmp_count", 32'(bus.cmp_count), 0);
    step();
    chk("idle_resp_valid", 32'(bus.resp_valid), 0);

    // Single compare, equal then unequal operands on requester 2
    set_pair(2, 3'b101, 3'b101);
    bus.req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'b0100);
    step();
    chk("single_valid", 32'(bus.resp_valid), 1);
    chk("single_id", 32'(bus.resp_id), 2);
    chk("single_eq", 32'(bus.resp_eq), 1);
    chk("single_cmp", 32'(bus.cmp_count), 1);
    chk("single_match", 32'(bus.match_count), 1);
    set_pair(2, 3'b101, 3'b100);
    #1;
    chk("single2_ready", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_valid = '0;
    chk("single2_id", 32'(bus.resp_id), 2);
    chk("single2_eq", 32'(bus.resp_eq), 0);
    chk("single2_cmp", 32'(bus.cmp_count), 2);
    chk("single2_match", 32'(bus.match_count), 1);

    // rr_ptr is now 3: wrap to 0, then skip 1 to reach 2
    set_pair(0, 3'b001, 3'b001);
    bus.req_valid = 4'b0101;
    #1;
    chk("wrap_ready0", 32'(bus.req_ready), 32'b0001);
    step();
    chk("wrap_id0", 32'(bus.resp_id), 0);
    chk("wrap_ready2", 32'(bus.req_ready), 32'b0100);
    step();
    chk("wrap_id2", 32'(bus.resp_id), 2);
    set_pair(3, 3'b111, 3'b111);
    bus.req_valid = 4'b1000;
    #1;
    chk("wrap_ptr3_ready", 32'(bus.req_ready), 32'b1000);
    step();
    chk("wrap_id3", 32'(bus.resp_id), 3);

    // Clear counters with no transfer pending, then full round-robin
    bus.req_valid  = '0;
    bus.clr_counts = 1'b1;
    step();
    bus.clr_counts = 1'b0;
    chk("clr_cmp", 32'(bus.cmp_count), 0);
    chk("clr_match", 32'(bus.match_count), 0);
    chk("clr_drained", 32'(bus.resp_valid), 0);
    set_pair(1, 3'b010, 3'b011);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr_ready_%0d", k), 32'(bus.req_ready), 32'(1) << (k % 4));
      step();
      chk($sformatf("rr_valid_%0d", k), 32'(bus.resp_valid), 1);
      chk($sformatf("rr_id_%0d", k), 32'(bus.resp_id), 32'(k % 4));
    end
    chk("rr_cmp", 32'(bus.cmp_count), 8);
    chk("rr_match", 32'(bus.match_count), 4);

    // Back-pressure: response for requester 3 (equal) must hold
    bus.req_valid  = 4'b0011;
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_ready_%0d", k), 32'(bus.req_ready), 0);
      step();
      chk($sformatf("bp_id_%0d", k), 32'(bus.resp_id), 3);
      chk($sformatf("bp_eq_%0d", k), 32'(bus.resp_eq), 1);
      chk($sformatf("bp_valid_%0d", k), 32'(bus.resp_valid), 1);
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid = '0;
    chk("bp_new_id", 32'(bus.resp_id), 0);
    chk("bp_new_eq", 32'(bus.resp_eq), 1);
    step();
    chk("drain_valid", 32'(bus.resp_valid), 0);
    chk("bp_cmp", 32'(bus.cmp_count), 9);

    // Asynchronous reset mid-cycle with a pending response
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    step();
    chk("pre_reset_valid", 32'(bus.resp_valid), 1);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    chk("async_valid", 32'(bus.resp_valid), 0);
    chk("async_id", 32'(bus.resp_id), 0);
    chk("async_cmp", 32'(bus.cmp_count), 0);
    chk("async_match", 32'(bus.match_count), 0);
    step();
    ASYNCRESETN    = 1'b1;
    bus.resp_ready = 1'b1;
    #1;
    chk("post_reset_ready", 32'(bus.req_ready), 0);
    step();
    chk("post_reset_valid", 32'(bus.resp_valid), 0);

    // Saturation: 65535 equal compares from requester 0
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 65535; k++)
      step();
    chk("sat_cmp", 32'(bus.cmp_count), 32'hFFFF);
    chk("sat_match", 32'(bus.match_count), 32'hFFFF);
    step();
    chk("sat_hold_cmp", 32'(bus.cmp_count), 32'hFFFF);
    chk("sat_hold_match", 32'(bus.match_count), 32'hFFFF);

    // Clear beats a same-cycle transfer; the response is still delivered
    set_pair(2, 3'b110, 3'b110);
    bus.req_valid  = 4'b0100;
    bus.clr_counts = 1'b1;
    #1;
    chk("clrx_ready", 32'(bus.req_ready), 32'b0100);
    step();
    bus.clr_counts = 1'b0;
    bus.req_valid  = '0;
    chk("clrx_cmp", 32'(bus.cmp_count), 0);
    chk("clrx_match", 32'(bus.match_count), 0);
    chk("clrx_valid", 32'(bus.resp_valid), 1);
    chk("clrx_id", 32'(bus.resp_id), 2);
    chk("clrx_eq", 32'(bus.resp_eq), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
